// File: rtl/frame_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : frame_rd_sched
// Purpose  : Read-side scheduler for the HDMI-to-PCIe frame FIFO. It accepts
//            one-cycle burst requests from the host DMA read engine. It waits
//            for enough FIFO water level, with a timeout. It then issues a
//            fixed-length burst of beat slots and pads underruns with a fill
//            word. It tracks beat and frame position so the host can align
//            beats to frames.
// Revision : 1.0 - initial release
// ============================================================================
module frame_rd_sched #(
   parameter int unsigned  BURST_LEN   = 256,
   parameter int unsigned  FRAME_BEATS = 153600,
   parameter int unsigned  LEVEL_W     = 13,
   parameter int unsigned  TIMEOUT     = 1023,
   parameter logic [127:0] FILL_WORD   = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA
) (
   input  logic               pcie_clk,
   input  logic               rst_n,
   input  logic               cfg_en,
   input  logic               frame_sync,
   input  logic               host_req,
   output logic               host_ack,
   output logic               busy,
   output logic               fifo_rd_en,
   input  logic [127:0]       fifo_rd_data,
   input  logic               fifo_empty,
   input  logic [LEVEL_W-1:0] fifo_level,
   output logic               out_vld,
   output logic [127:0]       out_data,
   output logic               out_sof,
   output logic               out_last,
   output logic [31:0]        frame_cnt,
   output logic [15:0]        underrun_cnt,
   output logic [1:0]         state
);

   // Timeout counter only needs to reach TIMEOUT.
   localparam int unsigned     C_TO_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [C_TO_W-1:0] C_TO_LIMIT = C_TO_W'(TIMEOUT);
   localparam logic [11:0]     C_LAST_SLOT = 12'(BURST_LEN - 1);
   localparam logic [17:0]     C_LAST_BEAT = 18'(FRAME_BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [C_TO_W-1:0]   to_q, to_d;
   logic [11:0]         slot_q, slot_d;
   logic [17:0]         beat_q, beat_d;
   logic                frame_pend_q, frame_pend_d;
   logic [31:0]         frame_cnt_q, frame_cnt_d;
   logic [15:0]         underrun_q, underrun_d;
   logic                vld_q, vld_d;
   logic                rd_q, rd_d;
   logic                sof_q, sof_d;
   logic                last_q, last_d;

   logic                w_level_ok;
   logic                w_slot;
   logic                w_apply_frame;

   assign w_level_ok = (32'(fifo_level) >= BURST_LEN);

   // FSM state register, timeout counter and burst slot counter.
   always_ff @(posedge pcie_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         to_q    <= '0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         slot_q  <= slot_d;
      end
   end

   // Next state, request acceptance and per-slot FIFO read strobe.
   always_comb begin
      state_d       = state_q;
      to_d          = to_q;
      slot_d        = slot_q;
      host_ack      = 1'b0;
      fifo_rd_en    = 1'b0;
      w_slot        = 1'b0;
      w_apply_frame = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A pending or same-cycle frame start is applied before a new
            // burst is accepted, so that burst begins at beat 0.
            w_apply_frame = frame_pend_q | frame_sync;
            if (host_req && cfg_en) begin
               host_ack = 1'b1;
               state_d  = S_WAIT;
               to_d     = '0;
               slot_d   = '0;
            end
         end
         S_WAIT: begin
            if (!cfg_en) begin
               state_d = S_IDLE;
            end else if (w_level_ok || (to_q == C_TO_LIMIT)) begin
               // A timeout forces the burst out even though it may be padded.
               state_d = S_BURST;
               slot_d  = '0;
            end else begin
               to_d = to_q + C_TO_W'(1);
            end
         end
         S_BURST: begin
            // Never strobe an empty FIFO; the slot is padded instead.
            w_slot     = 1'b1;
            fifo_rd_en = ~fifo_empty;
            // A burst always runs to completion, even if cfg_en drops.
            if (slot_q == C_LAST_SLOT) begin
               state_d = S_IDLE;
            end else begin
               slot_d = slot_q + 12'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Beat output stage, beat/frame position and underrun statistics.
   always_ff @(posedge pcie_clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q       <= '0;
         frame_pend_q <= 1'b0;
         frame_cnt_q  <= '0;
         underrun_q   <= '0;
         vld_q        <= 1'b0;
         rd_q         <= 1'b0;
         sof_q        <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         beat_q       <= beat_d;
         frame_pend_q <= frame_pend_d;
         frame_cnt_q  <= frame_cnt_d;
         underrun_q   <= underrun_d;
         vld_q        <= vld_d;
         rd_q         <= rd_d;
         sof_q        <= sof_d;
         last_q       <= last_d;
      end
   end

   // Each slot becomes a beat one cycle later; frame starts only land in IDLE.
   always_comb begin
      beat_d       = beat_q;
      frame_cnt_d  = frame_cnt_q;
      underrun_d   = underrun_q;
      frame_pend_d = frame_pend_q | frame_sync;
      vld_d        = w_slot;
      rd_d         = w_slot & fifo_rd_en;
      sof_d        = w_slot & (beat_q == 18'd0);
      last_d       = w_slot & (slot_q == C_LAST_SLOT);
      if (w_apply_frame) begin
         beat_d       = '0;
         frame_cnt_d  = frame_cnt_q + 32'd1;
         frame_pend_d = 1'b0;
      end else if (w_slot) begin
         beat_d = (beat_q == C_LAST_BEAT) ? 18'd0 : beat_q + 18'd1;
      end
      if (w_slot && fifo_empty && (underrun_q != 16'hFFFF)) begin
         underrun_d = underrun_q + 16'd1;
      end
   end

   // The FIFO presents read data one cycle after the strobe, i.e. in the
   // beat cycle, so the pad/real selection is made here rather than stored.
   assign out_data     = vld_q ? (rd_q ? fifo_rd_data : FILL_WORD) : 128'd0;
   assign out_vld      = vld_q;
   assign out_sof      = sof_q;
   assign out_last     = last_q;
   assign busy         = (state_q != S_IDLE);
   assign state        = state_q;
   assign frame_cnt    = frame_cnt_q;
   assign underrun_cnt = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_rd_sched
// Purpose  : Directed self-checking bench for frame_rd_sched, using reduced
//            burst, frame and timeout sizes and a behavioural FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_rd_sched;

   localparam int BL = 8;
   localparam int FB = 20;
   localparam int TO = 15;
   localparam logic [127:0] FILL  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
   localparam logic [95:0]  TAGHI = 96'hD0D0D0D0_D0D0D0D0_D0D0D0D0;

   logic         pcie_clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_en = 1'b0;
   logic         frame_sync = 1'b0;
   logic         host_req = 1'b0;
   logic         host_ack, busy, fifo_rd_en, out_vld, out_sof, out_last;
   logic [127:0] fifo_rd_data = '0;
   logic [127:0] out_data;
   logic         fifo_empty;
   logic [12:0]  fifo_level;
   logic [31:0]  frame_cnt;
   logic [15:0]  underrun_cnt;
   logic [1:0]   state;

   int checks = 0;
   int errors = 0;

   // FIFO model state
   int   avail = 0, rd_ptr = 0, rd_cnt = 0, overread = 0;
   int   set_avail = 0, set_ptr = 0;
   logic set_pulse = 1'b0;

   // Bench expectation model
   int exp_beat = 0;
   int exp_ptr  = 0;
   int lat;

   always #5 pcie_clk = ~pcie_clk;

   frame_rd_sched #(
      .BURST_LEN   (BL),
      .FRAME_BEATS (FB),
      .LEVEL_W     (13),
      .TIMEOUT     (TO)
   ) dut (
      .pcie_clk     (pcie_clk),
      .rst_n        (rst_n),
      .cfg_en       (cfg_en),
      .frame_sync   (frame_sync),
      .host_req     (host_req),
      .host_ack     (host_ack),
      .busy         (busy),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty),
      .fifo_level   (fifo_level),
      .out_vld      (out_vld),
      .out_data     (out_data),
      .out_sof      (out_sof),
      .out_last     (out_last),
      .frame_cnt    (frame_cnt),
      .underrun_cnt (underrun_cnt),
      .state        (state)
   );

   assign fifo_empty = (avail == 0);
   assign fifo_level = 13'(avail);

   // FIFO model: data word = tag | sequence number, valid one cycle after strobe.
   always @(posedge pcie_clk) begin
      if (set_pulse) begin
         avail  <= set_avail;
         rd_ptr <= set_ptr;
         rd_cnt <= 0;
      end else if (fifo_rd_en) begin
         if (avail == 0) overread <= overread + 1;
         else            avail <= avail - 1;
         fifo_rd_data <= {TAGHI, 32'(rd_ptr)};
         rd_ptr <= rd_ptr + 1;
         rd_cnt <= rd_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_fifo(input int n, input int p);
      @(negedge pcie_clk);
      set_avail = n;
      set_ptr   = p;
      set_pulse = 1'b1;
      @(negedge pcie_clk);
      set_pulse = 1'b0;
   endtask

   // One host burst: request, then collect BL beats against the bench model.
   task automatic burst(input string tag, input int n_real, input bit fs_req,
                        input logic [7:0] fs_mask, input int cfg_off,
                        output int first_lat);
      int beats, l, data_bad, sof_bad, last_bad, r0;
      logic [127:0] exp_d;
      logic [1:0]   st_last;
      beats = 0; l = 0; data_bad = 0; sof_bad = 0; last_bad = 0;
      first_lat = -1; st_last = 2'd3;
      @(negedge pcie_clk);
      r0 = rd_cnt;
      host_req   = 1'b1;
      frame_sync = fs_req;
      #1;
      chk({tag, " ack"}, 128'(host_ack), 128'(1));
      if (fs_req) exp_beat = 0;
      @(negedge pcie_clk);
      host_req   = 1'b0;
      frame_sync = 1'b0;
      l = 1;
      chk({tag, " wait_state"}, 128'(state), 128'(1));
      while (beats < BL && l < 200) begin
         @(negedge pcie_clk);
         l++;
         frame_sync = 1'b0;
         if (out_vld) begin
            if (beats == 0) first_lat = l;
            exp_d = (beats < n_real) ? {TAGHI, 32'(exp_ptr)} : FILL;
            if (beats < n_real) exp_ptr++;
            if (out_data !== exp_d) data_bad++;
            if (out_sof !== (exp_beat == 0)) sof_bad++;
            if (out_last !== (beats == BL - 1)) last_bad++;
            if (beats == BL - 1) st_last = state;
            exp_beat   = (exp_beat == FB - 1) ? 0 : exp_beat + 1;
            frame_sync = fs_mask[beats];
            if (beats == cfg_off) cfg_en = 1'b0;
            beats++;
         end
      end
      @(negedge pcie_clk);
      frame_sync = 1'b0;
      chk({tag, " beats"},    128'(beats), 128'(BL));
      chk({tag, " data"},     128'(data_bad), 128'(0));
      chk({tag, " sof"},      128'(sof_bad), 128'(0));
      chk({tag, " last"},     128'(last_bad), 128'(0));
      chk({tag, " idle"},     128'(st_last), 128'(0));
      chk({tag, " no_extra"}, 128'(out_vld), 128'(0));
      chk({tag, " reads"},    128'(rd_cnt - r0), 128'(n_real));
   endtask

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge pcie_clk);
      chk("rst out_vld", 128'(out_vld), 128'(0));
      chk("rst host_ack", 128'(host_ack), 128'(0));
      chk("rst busy", 128'(busy), 128'(0));
      chk("rst rd_en", 128'(fifo_rd_en), 128'(0));
      chk("rst out_data", out_data, 128'(0));
      chk("rst frame_cnt", 128'(frame_cnt), 128'(0));
      chk("rst underrun", 128'(underrun_cnt), 128'(0));
      chk("rst state", 128'(state), 128'(0));
      rst_n  = 1'b1;
      cfg_en = 1'b1;

      // Plenty of data: in-order real beats, minimum latency 3
      set_fifo(12, 0);
      exp_ptr = 0; exp_beat = 0;
      burst("s1", 8, 1'b0, 8'h00, -1, lat);
      chk("s1 latency", 128'(lat), 128'(3));
      chk("s1 underrun", 128'(underrun_cnt), 128'(0));
      chk("s1 busy", 128'(busy), 128'(0));

      // Low level: timeout after TO+1 wait cycles, 3 real beats then 5 fills
      set_fifo(3, 100);
      exp_ptr = 100;
      burst("s2", 3, 1'b0, 8'h00, -1, lat);
      chk("s2 latency", 128'(lat), 128'(3 + TO));
      chk("s2 underrun", 128'(underrun_cnt), 128'(5));
      chk("s2 frame_cnt", 128'(frame_cnt), 128'(0));

      // frame_sync with host_req in IDLE, then frame wrap inside third burst
      set_fifo(40, 200);
      exp_ptr = 200;
      burst("s3a", 8, 1'b1, 8'h00, -1, lat);
      chk("s3 frame_cnt", 128'(frame_cnt), 128'(1));
      burst("s3b", 8, 1'b0, 8'h00, -1, lat);
      burst("s3c", 8, 1'b0, 8'h00, -1, lat);
      chk("s3 frame_cnt_wrap", 128'(frame_cnt), 128'(1));

      // Two frame_sync pulses mid-burst: full burst, one frame at next IDLE
      burst("s4a", 8, 1'b0, 8'b0010_0100, -1, lat);
      chk("s4 frame_cnt", 128'(frame_cnt), 128'(2));
      exp_beat = 0;
      burst("s4b", 8, 1'b0, 8'h00, -1, lat);
      chk("s4 frame_cnt_once", 128'(frame_cnt), 128'(2));

      // cfg_en drop mid-burst: burst completes, further requests ignored
      set_fifo(20, 300);
      exp_ptr = 300;
      burst("s5", 8, 1'b0, 8'h00, 3, lat);
      @(negedge pcie_clk);
      host_req = 1'b1;
      #1;
      chk("s5 no_ack", 128'(host_ack), 128'(0));
      @(negedge pcie_clk);
      host_req = 1'b0;
      chk("s5 stay_idle", 128'(state), 128'(0));

      // cfg_en drop while waiting for level: back to IDLE, no burst
      cfg_en = 1'b1;
      set_fifo(0, 0);
      @(negedge pcie_clk);
      host_req = 1'b1;
      #1;
      chk("w ack", 128'(host_ack), 128'(1));
      @(negedge pcie_clk);
      host_req = 1'b0;
      chk("w state", 128'(state), 128'(1));
      @(negedge pcie_clk);
      cfg_en = 1'b0;
      @(negedge pcie_clk);
      chk("w abort", 128'(state), 128'(0));
      n = 0;
      repeat (25) begin
         @(negedge pcie_clk);
         if (out_vld) n++;
      end
      chk("w no_beats", 128'(n), 128'(0));
      cfg_en = 1'b1;

      // Asynchronous reset in the middle of a burst
      set_fifo(20, 400);
      @(negedge pcie_clk);
      host_req = 1'b1;
      @(negedge pcie_clk);
      host_req = 1'b0;
      n = 0;
      for (int i = 0; i < 50 && n < 3; i++) begin
         @(negedge pcie_clk);
         if (out_vld) n++;
      end
      chk("r beats_before", 128'(n), 128'(3));
      #3;
      rst_n = 1'b0;
      #1;
      chk("r out_vld", 128'(out_vld), 128'(0));
      chk("r rd_en", 128'(fifo_rd_en), 128'(0));
      chk("r busy", 128'(busy), 128'(0));
      chk("r frame_cnt", 128'(frame_cnt), 128'(0));
      chk("r underrun", 128'(underrun_cnt), 128'(0));
      chk("r state", 128'(state), 128'(0));
      @(negedge pcie_clk);
      @(negedge pcie_clk);
      rst_n = 1'b1;
      set_fifo(20, 700);
      exp_ptr = 700; exp_beat = 0;
      burst("s6", 8, 1'b0, 8'h00, -1, lat);
      chk("s6 latency", 128'(lat), 128'(3));
      chk("s6 frame_cnt", 128'(frame_cnt), 128'(0));
      chk("s6 underrun", 128'(underrun_cnt), 128'(0));

      chk("no overread", 128'(overread), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
